pc_sequencer: RTL

//  Parametrised program-counter sequencer: the next-generation PC/interrupt front end of the core.
//  Per executed instruction it computes the next fetch address from opcode, flags and the selected register.
//  It owns a return-address LIFO and an IRQ_N-channel prioritised, maskable, nestable interrupt controller.

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/pc_sequencer_ret_stack.sv | 49 ++++
 rtl/pc_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared opcode encodings for the PC sequencer and the decode stage.
package pc_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_JEQ  = 4'd1;
  localparam logic [3:0] OP_JGT  = 4'd2;
  localparam logic [3:0] OP_JLT  = 4'd3;
  localparam logic [3:0] OP_JIS  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_NEX  = 4'd6;
  localparam logic [3:0] OP_CALL = 4'd7;
  localparam logic [3:0] OP_RET  = 4'd8;
  localparam logic [3:0] OP_EI   = 4'd9;
  localparam logic [3:0] OP_DI   = 4'd10;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. dout always shows the top entry (mem[sp-1]);
// a push while full or a pop while empty is ignored here and flagged by the caller.
module ret_stack #(
  parameter int DEPTH = 256,
  parameter int W     = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     full,
  output logic                     empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SP_W = AW + 1;

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp_reg;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            do_push;
  logic            do_pop;

  assign full    = (sp_reg == SP_W'(DEPTH));
  assign empty   = (sp_reg == '0);
  assign wr_idx  = sp_reg[AW-1:0];
  assign rd_idx  = wr_idx - AW'(1);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty & ~push;
  assign dout    = mem[rd_idx];
  assign sp      = sp_reg;

  // Storage is not reset: contents are meaningless once sp returns to zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  // Occupancy counter; saturates naturally because full/empty gate the updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         sp_reg <= '0;
    else if (do_push) sp_reg <= sp_reg + SP_W'(1);
    else if (do_pop)  sp_reg <= sp_reg - SP_W'(1);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, return stack and a
// prioritised, maskable, nestable interrupt front end.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 256,
  parameter int IRQ_N       = 3,
  parameter int VEC_BASE    = 2,
  parameter int RESET_PC    = 0,
  parameter int NEST        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          step,
  input  logic [3:0]                    op,
  input  logic [ADDR_W-1:0]             target,
  input  logic [DATA_W-1:0]             reg_val,
  input  logic                          lt,
  input  logic                          gt,
  input  logic                          eq,
  input  logic                          aeq,
  input  logic                          hlt,
  input  logic [IRQ_N-1:0]              irq,
  input  logic [IRQ_N-1:0]              irq_mask,
  input  logic                          clr_err,
  output logic [ADDR_W-1:0]             pc,
  output logic [$clog2(STACK_DEPTH):0]  sp,
  output logic                          in_irq,
  output logic [$clog2(IRQ_N):0]        irq_lvl,
  output logic [IRQ_N-1:0]              irq_ack,
  output logic                          irq_done,
  output logic                          stack_ovf,
  output logic                          stack_unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int LVL_W = $clog2(IRQ_N) + 1;
  localparam int FC_W  = $clog2(IRQ_N + 1);
  localparam int IDX_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;

  // Architectural state
  logic [ADDR_W-1:0] pc_reg;
  logic              ie_reg;
  logic [IRQ_N-1:0]  pending_reg;
  logic              in_irq_reg;
  logic [LVL_W-1:0]  irq_lvl_reg;
  logic [IRQ_N-1:0]  irq_ack_reg;
  logic              irq_done_reg;
  logic              stack_ovf_reg;
  logic              stack_unf_reg;
  logic [FC_W-1:0]   fcnt_reg;

  // Frame file: the level and stack depth to restore when a handler returns
  logic [LVL_W-1:0]  frame_lvl [IRQ_N];
  logic [SP_W-1:0]   frame_sp  [IRQ_N];

  // Return stack interface
  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_din;
  logic [ADDR_W-1:0] stk_dout;
  logic [SP_W-1:0]   stk_sp;
  logic              stk_full;
  logic              stk_empty;

  // Decision signals
  logic [LVL_W-1:0]  best;
  logic              preempt_ok;
  logic              accept;
  logic [IRQ_N-1:0]  ack_vec;
  logic              call_exec;
  logic              ret_exec;
  logic              ovf_event;
  logic              unf_event;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] dest;
  logic [ADDR_W-1:0] pc_next;
  logic [FC_W-1:0]   fcnt_top;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;
  logic              frame_hit;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (stk_din),
    .dout  (stk_dout),
    .sp    (stk_sp),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Priority encoder: lowest pending index wins; IRQ_N means nothing pending.
  always_comb begin
    best = LVL_W'(IRQ_N);
    for (int k = IRQ_N - 1; k >= 0; k--) begin
      if (pending_reg[k]) best = LVL_W'(k);
    end
  end

  assign pc_inc     = pc_reg + ADDR_W'(1);
  assign dest       = (target != '0) ? target : reg_val[ADDR_W-1:0];
  // Outside a handler irq_lvl is IRQ_N, so any pending channel qualifies.
  assign preempt_ok = !in_irq_reg || ((NEST != 0) && (best < irq_lvl_reg));
  assign accept     = step & ie_reg & (|pending_reg) & ~stk_full & preempt_ok;
  assign ack_vec    = accept ? (IRQ_N'(1) << best) : '0;
  assign call_exec  = step & ~accept & (op == OP_CALL);
  assign ret_exec   = step & ~accept & (op == OP_RET);
  assign ovf_event  = call_exec & stk_full;
  assign unf_event  = ret_exec & stk_empty;

  // An accepted interrupt that interrupts a non-halted NEX resumes after it.
  assign stk_push = accept | call_exec;
  assign stk_pop  = ret_exec;
  assign stk_din  = (accept && !((op == OP_NEX) && !hlt)) ? pc_reg : pc_inc;

  assign fcnt_top  = fcnt_reg - FC_W'(1);
  assign top_idx   = fcnt_top[IDX_W-1:0];
  assign push_idx  = fcnt_reg[IDX_W-1:0];
  // The RET that brings the stack back to its depth at entry ends the handler.
  assign frame_hit = in_irq_reg && (fcnt_reg != '0) && !stk_empty &&
                     ((stk_sp - SP_W'(1)) == frame_sp[top_idx]);

  // Next-PC mux: interrupt vector first, otherwise the executed opcode.
  always_comb begin
    pc_next = pc_reg;
    if (accept) begin
      pc_next = ADDR_W'(VEC_BASE) + ADDR_W'(best);
    end else if (step) begin
      case (op)
        OP_JEQ:  pc_next = ((aeq & eq) | eq) ? dest : pc_inc;
        OP_JGT:  pc_next = ((aeq & eq) | gt) ? dest : pc_inc;
        OP_JLT:  pc_next = ((aeq & eq) | lt) ? dest : pc_inc;
        OP_JIS:  pc_next = (reg_val != '0) ? dest : pc_inc;
        OP_JMP:  pc_next = dest;
        OP_NEX:  pc_next = hlt ? pc_reg : pc_inc;
        OP_CALL: pc_next = dest;
        OP_RET:  pc_next = stk_empty ? pc_inc : stk_dout;
        default: pc_next = pc_inc;
      endcase
    end
  end

  // Frame file write on interrupt entry; stale entries are harmless after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_lvl[push_idx] <= irq_lvl_reg;
      frame_sp[push_idx]  <= stk_sp;
    end
  end

  // Sequencer state: pending capture runs every cycle, everything else on step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg        <= ADDR_W'(RESET_PC);
      ie_reg        <= 1'b1;
      pending_reg   <= '0;
      in_irq_reg    <= 1'b0;
      irq_lvl_reg   <= LVL_W'(IRQ_N);
      irq_ack_reg   <= '0;
      irq_done_reg  <= 1'b0;
      stack_ovf_reg <= 1'b0;
      stack_unf_reg <= 1'b0;
      fcnt_reg      <= '0;
    end else begin
      pending_reg  <= (pending_reg | (irq & irq_mask)) & ~ack_vec;
      irq_ack_reg  <= ack_vec;
      irq_done_reg <= 1'b0;
      if (step) begin
        pc_reg        <= pc_next;
        stack_ovf_reg <= (stack_ovf_reg & ~clr_err) | ovf_event;
        stack_unf_reg <= (stack_unf_reg & ~clr_err) | unf_event;
        if (accept) begin
          fcnt_reg    <= fcnt_reg + FC_W'(1);
          irq_lvl_reg <= best;
          in_irq_reg  <= 1'b1;
        end else begin
          if (op == OP_EI)      ie_reg <= 1'b1;
          else if (op == OP_DI) ie_reg <= 1'b0;
          if (ret_exec && frame_hit) begin
            fcnt_reg    <= fcnt_top;
            irq_lvl_reg <= frame_lvl[top_idx];
            if (fcnt_reg == FC_W'(1)) begin
              in_irq_reg   <= 1'b0;
              irq_done_reg <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign pc        = pc_reg;
  assign sp        = stk_sp;
  assign in_irq    = in_irq_reg;
  assign irq_lvl   = irq_lvl_reg;
  assign irq_ack   = irq_ack_reg;
  assign irq_done  = irq_done_reg;
  assign stack_ovf = stack_ovf_reg;
  assign stack_unf = stack_unf_reg;

endmodule
